// File: rtl/ysyx_23060136_ifu_fetch_pkg.sv
// ysyx_23060136_ifu_pkg
//   Shared types and constants for the instruction fetch unit:
//   FSM state encoding, fetch exception causes, PC-update operations,
//   reset PC, NOP encoding and the AXI OKAY response code.
package ysyx_23060136_ifu_pkg;

  localparam int unsigned IFU_XLEN     = 32;
  localparam logic [31:0] IFU_RST_PC   = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [1:0]  RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE         = 2'b00,
    EXC_ACCESS_FAULT = 2'b01,
    EXC_MISALIGNED   = 2'b10
  } ifu_exc_cause_e;

  // How req_pc moves on the next clock edge.
  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_INCR   = 2'd1,
    PC_TARGET = 2'd2,
    PC_REDIR  = 2'd3
  } pc_op_e;

endpackage

// File: rtl/ysyx_23060136_ifu_fetch_if.sv
// ysyx_23060136_ifu_fetch_if
//   AXI4-Lite read channels (AR + R) between the fetch unit and memory.
//   Ports:
//     IFU_arvalid / IFU_araddr / IFU_arready   address channel
//     IFU_rvalid / IFU_rdata / IFU_rresp / IFU_rready   data channel
//   Modports: master (fetch unit side), slave (memory side).
interface ysyx_23060136_ifu_fetch_if #(
  parameter int XLEN = 32
);

  logic            IFU_arvalid;
  logic [XLEN-1:0] IFU_araddr;
  logic            IFU_arready;
  logic            IFU_rvalid;
  logic [31:0]     IFU_rdata;
  logic [1:0]      IFU_rresp;
  logic            IFU_rready;

  modport master (
    output IFU_arvalid, IFU_araddr, IFU_rready,
    input  IFU_arready, IFU_rvalid, IFU_rdata, IFU_rresp
  );

  modport slave (
    input  IFU_arvalid, IFU_araddr, IFU_rready,
    output IFU_arready, IFU_rvalid, IFU_rdata, IFU_rresp
  );

endinterface

// File: rtl/ysyx_23060136_ifu_fetch_pc_gen.sv
// ysyx_23060136_ifu_pc_gen
//   Fetch PC bookkeeping: current request PC, pending redirect PC and the
//   drop flag that marks an in-flight response as stale.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     pc_op         next req_pc selection (keep / +4 / target / redir_pc)
//     arm_drop      capture target into redir_pc and mark in-flight beat stale
//     clr_drop      stale beat has been consumed; clear drop
//     target        redirect PC (already alignment-adjusted by the caller)
//     req_pc        PC of the current request / held instruction
//     drop          in-flight response must be discarded
module ysyx_23060136_ifu_pc_gen
  import ysyx_23060136_ifu_pkg::*;
#(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] RST_PC = XLEN'(IFU_RST_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_op_e          pc_op,
  input  logic            arm_drop,
  input  logic            clr_drop,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] req_pc,
  output logic            drop
);

  logic [XLEN-1:0] redir_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc   <= RST_PC;
      redir_pc <= RST_PC;
      drop     <= 1'b0;
    end else begin
      case (pc_op)
        PC_INCR:   req_pc <= req_pc + XLEN'(4);  // wraps modulo 2^XLEN
        PC_TARGET: req_pc <= target;
        PC_REDIR:  req_pc <= redir_pc;
        default:   req_pc <= req_pc;
      endcase

      // A later redirect simply overwrites redir_pc: latest target wins.
      if (clr_drop) begin
        drop <= 1'b0;
      end else if (arm_drop) begin
        drop     <= 1'b1;
        redir_pc <= target;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060136_ifu_fetch.sv
// ysyx_23060136_ifu_fetch
//   Instruction fetch unit. Owns the fetch PC, issues one AXI4-Lite read
//   per instruction and holds the result for the IF/ID segment register.
//   Advances only when ID consumes (!FORWARD_stallID); honours branch
//   redirects, including those that land on an in-flight bus request.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     FORWARD_stallID   ID holds; held instruction not consumed
//     BRANCH_flushIF    redirect request (only taken when not stalled)
//     BRANCH_target     redirect PC
//     bus               AXI4-Lite read master (AR/R)
//     IFU_o_valid       instruction held for ID
//     IFU_o_pc          PC of the held instruction
//     IFU_o_inst        held instruction, NOP when not valid
//     IFU_o_exc         fetch exception on held slot       (EXC_EN only)
//     IFU_o_exc_cause   01 access fault, 10 misaligned     (EXC_EN only)
//   Build option: define YSYX_23060136_IFU_EXC_EN to enable fetch
//   exceptions. Without it rresp is ignored and redirect targets are
//   forced to word alignment.
//
//   state  | meaning
//   S_REQ  | AR valid at req_pc, waiting for arready
//   S_WAIT | request accepted, waiting for the R beat
//   S_HOLD | instruction (or exception) presented to ID
module ysyx_23060136_ifu_fetch
  import ysyx_23060136_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_PC   = XLEN'(IFU_RST_PC),
  parameter logic [31:0]     NOP_INST = IFU_NOP_INST
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        FORWARD_stallID,
  input  logic                        BRANCH_flushIF,
  input  logic [XLEN-1:0]             BRANCH_target,
  ysyx_23060136_ifu_fetch_if.master   bus,
  output logic                        IFU_o_valid,
  output logic [XLEN-1:0]             IFU_o_pc,
  output logic [31:0]                 IFU_o_inst
`ifdef YSYX_23060136_IFU_EXC_EN
  ,
  output logic                        IFU_o_exc,
  output logic [1:0]                  IFU_o_exc_cause
`endif
);

  ifu_state_e      state;
  logic [31:0]     inst_q;
  logic            exc_q;
  ifu_exc_cause_e  exc_cause_q;

  logic [XLEN-1:0] req_pc;
  logic            drop;
  pc_op_e          pc_op;
  logic            arm_drop;
  logic            clr_drop;

  logic            redirect;
  logic [XLEN-1:0] target_eff;
  logic            misaligned;
  logic            resp_err;

  assign redirect = BRANCH_flushIF && !FORWARD_stallID;

`ifdef YSYX_23060136_IFU_EXC_EN
  assign target_eff = BRANCH_target;
  assign misaligned = |req_pc[1:0];
  assign resp_err   = (bus.IFU_rresp != RESP_OKAY);
  assign IFU_o_exc       = exc_q;
  assign IFU_o_exc_cause = exc_cause_q;
`else
  assign target_eff = {BRANCH_target[XLEN-1:2], 2'b00};
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
  logic unused_sink;
  assign unused_sink = ^{bus.IFU_rresp, BRANCH_target[1:0], exc_q, exc_cause_q};
`endif

  ysyx_23060136_ifu_pc_gen #(
    .XLEN   (XLEN),
    .RST_PC (RST_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst      (rst),
    .pc_op    (pc_op),
    .arm_drop (arm_drop),
    .clr_drop (clr_drop),
    .target   (target_eff),
    .req_pc   (req_pc),
    .drop     (drop)
  );

  // PC-side control. A redirect while a request is on the bus cannot
  // cancel it (AXI), so it is parked in redir_pc and the beat dropped.
  always_comb begin
    pc_op    = PC_KEEP;
    arm_drop = 1'b0;
    clr_drop = 1'b0;
    case (state)
      S_REQ: begin
        if (misaligned) begin
          if (redirect) pc_op = PC_TARGET;  // nothing issued, retarget freely
        end else if (redirect) begin
          arm_drop = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.IFU_rvalid) begin
          if (redirect) begin
            pc_op    = PC_TARGET;
            clr_drop = 1'b1;
          end else if (drop) begin
            pc_op    = PC_REDIR;
            clr_drop = 1'b1;
          end
        end else if (redirect) begin
          arm_drop = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect)              pc_op = PC_TARGET;
        else if (!FORWARD_stallID) pc_op = PC_INCR;
      end
      default: pc_op = PC_KEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      inst_q      <= NOP_INST;
      exc_q       <= 1'b0;
      exc_cause_q <= EXC_NONE;
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            if (!redirect) begin
              state       <= S_HOLD;
              inst_q      <= NOP_INST;
              exc_q       <= 1'b1;
              exc_cause_q <= EXC_MISALIGNED;
            end
          end else if (bus.IFU_arready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.IFU_rvalid) begin
            if (drop || redirect) begin
              state <= S_REQ;
            end else begin
              state <= S_HOLD;
              if (resp_err) begin
                inst_q      <= NOP_INST;
                exc_q       <= 1'b1;
                exc_cause_q <= EXC_ACCESS_FAULT;
              end else begin
                inst_q <= bus.IFU_rdata;
              end
            end
          end
        end
        S_HOLD: begin
          if (redirect || !FORWARD_stallID) begin
            state       <= S_REQ;
            exc_q       <= 1'b0;
            exc_cause_q <= EXC_NONE;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  // Outputs are decodes of registered state only.
  assign bus.IFU_arvalid = (state == S_REQ) && !misaligned;
  assign bus.IFU_araddr  = req_pc;
  assign bus.IFU_rready  = (state == S_WAIT);

  assign IFU_o_valid = (state == S_HOLD);
  assign IFU_o_pc    = req_pc;
  assign IFU_o_inst  = IFU_o_valid ? inst_q : NOP_INST;

endmodule

// File: tb/tb_ysyx_23060136_ifu_fetch.sv
// tb_ysyx_23060136_ifu_fetch
//   Directed bench for the fetch unit. Inputs change 1 time unit after the
//   rising edge; outputs are checked in the same window.
module tb_ysyx_23060136_ifu_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] INST = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_inst;
`ifdef YSYX_23060136_IFU_EXC_EN
  logic        o_exc;
  logic [1:0]  o_exc_cause;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ysyx_23060136_ifu_fetch_if #(.XLEN(32)) bus ();

  ysyx_23060136_ifu_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .FORWARD_stallID (stall),
    .BRANCH_flushIF  (flush),
    .BRANCH_target   (target),
    .bus             (bus),
    .IFU_o_valid     (o_valid),
    .IFU_o_pc        (o_pc),
    .IFU_o_inst      (o_inst)
`ifdef YSYX_23060136_IFU_EXC_EN
    ,
    .IFU_o_exc       (o_exc),
    .IFU_o_exc_cause (o_exc_cause)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    stall           = 1'b0;
    flush           = 1'b0;
    target          = 32'h0;
    bus.IFU_arready = 1'b0;
    bus.IFU_rvalid  = 1'b0;
    bus.IFU_rdata   = INST;
    bus.IFU_rresp   = 2'b00;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check_eq("rst_arvalid", 32'(bus.IFU_arvalid), 32'd1);
    check_eq("rst_araddr", bus.IFU_araddr, 32'h8000_0000);
    check_eq("rst_rready", 32'(bus.IFU_rready), 32'd0);
    check_eq("rst_o_valid", 32'(o_valid), 32'd0);
    check_eq("rst_o_inst", o_inst, NOP);

    // back-to-back fetch, memory always ready
    bus.IFU_arready = 1'b1;
    bus.IFU_rvalid  = 1'b1;
    tick();
    check_eq("t1_wait_rready", 32'(bus.IFU_rready), 32'd1);
    check_eq("t1_wait_arvalid", 32'(bus.IFU_arvalid), 32'd0);
    check_eq("t1_wait_o_valid", 32'(o_valid), 32'd0);
    tick();
    check_eq("t1_hold0_valid", 32'(o_valid), 32'd1);
    check_eq("t1_hold0_pc", o_pc, 32'h8000_0000);
    check_eq("t1_hold0_inst", o_inst, INST);
    tick();
    check_eq("t1_req1_arvalid", 32'(bus.IFU_arvalid), 32'd1);
    check_eq("t1_req1_araddr", bus.IFU_araddr, 32'h8000_0004);
    check_eq("t1_req1_o_valid", 32'(o_valid), 32'd0);
    tick();
    tick();
    check_eq("t1_hold1_valid", 32'(o_valid), 32'd1);
    check_eq("t1_hold1_pc", o_pc, 32'h8000_0004);

    // stall holds the slot
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_stall_valid", 32'(o_valid), 32'd1);
      check_eq("t2_stall_pc", o_pc, 32'h8000_0004);
      check_eq("t2_stall_inst", o_inst, INST);
      check_eq("t2_stall_arvalid", 32'(bus.IFU_arvalid), 32'd0);
    end
    stall = 1'b0;
    tick();
    check_eq("t2_release_araddr", bus.IFU_araddr, 32'h8000_0008);
    check_eq("t2_release_arvalid", 32'(bus.IFU_arvalid), 32'd1);

    // redirect while AR is stalled by arready=0
    rst             = 1'b1;
    bus.IFU_arready = 1'b0;
    bus.IFU_rvalid  = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check_eq("t3_c1_araddr", bus.IFU_araddr, 32'h8000_0000);
    flush  = 1'b1;
    target = 32'h8000_0100;
    tick();
    flush = 1'b0;
    check_eq("t3_c2_araddr", bus.IFU_araddr, 32'h8000_0000);
    check_eq("t3_c2_arvalid", 32'(bus.IFU_arvalid), 32'd1);
    tick();
    check_eq("t3_c3_araddr", bus.IFU_araddr, 32'h8000_0000);
    bus.IFU_arready = 1'b1;
    tick();
    bus.IFU_arready = 1'b0;
    check_eq("t3_wait_rready", 32'(bus.IFU_rready), 32'd1);
    check_eq("t3_wait_o_valid", 32'(o_valid), 32'd0);
    bus.IFU_rvalid = 1'b1;
    tick();
    bus.IFU_rvalid = 1'b0;
    check_eq("t3_drop_o_valid", 32'(o_valid), 32'd0);
    check_eq("t3_new_arvalid", 32'(bus.IFU_arvalid), 32'd1);
    check_eq("t3_new_araddr", bus.IFU_araddr, 32'h8000_0100);

    // redirect coincident with rvalid
    bus.IFU_arready = 1'b1;
    tick();
    bus.IFU_arready = 1'b0;
    bus.IFU_rvalid  = 1'b1;
    flush           = 1'b1;
    target          = 32'h8000_0040;
    tick();
    bus.IFU_rvalid = 1'b0;
    flush          = 1'b0;
    check_eq("t4_o_valid", 32'(o_valid), 32'd0);
    check_eq("t4_araddr", bus.IFU_araddr, 32'h8000_0040);
    check_eq("t4_arvalid", 32'(bus.IFU_arvalid), 32'd1);

    // two redirects while drop pending: latest wins
    bus.IFU_arready = 1'b1;
    tick();
    bus.IFU_arready = 1'b0;
    flush           = 1'b1;
    target          = 32'h8000_0100;
    tick();
    target = 32'h8000_0200;
    tick();
    flush = 1'b0;
    check_eq("t5_still_wait", 32'(bus.IFU_rready), 32'd1);
    bus.IFU_rvalid = 1'b1;
    tick();
    bus.IFU_rvalid = 1'b0;
    check_eq("t5_araddr", bus.IFU_araddr, 32'h8000_0200);
    check_eq("t5_o_valid", 32'(o_valid), 32'd0);

    // flush while stalled is ignored; re-presented flush is taken
    bus.IFU_arready = 1'b1;
    bus.IFU_rvalid  = 1'b1;
    tick();
    tick();
    check_eq("t7_hold_pc", o_pc, 32'h8000_0200);
    check_eq("t7_hold_valid", 32'(o_valid), 32'd1);
    stall  = 1'b1;
    flush  = 1'b1;
    target = 32'h8000_0300;
    tick();
    check_eq("t7_ignored_valid", 32'(o_valid), 32'd1);
    check_eq("t7_ignored_pc", o_pc, 32'h8000_0200);
    stall = 1'b0;
    tick();
    flush = 1'b0;
    check_eq("t7_taken_araddr", bus.IFU_araddr, 32'h8000_0300);
    check_eq("t7_taken_o_valid", 32'(o_valid), 32'd0);
    tick();
    tick();
    check_eq("t7_hold_pc2", o_pc, 32'h8000_0300);

    // error response
    tick();
    check_eq("t8_req_araddr", bus.IFU_araddr, 32'h8000_0304);
    bus.IFU_rresp = 2'b10;
    bus.IFU_rdata = 32'h0020_0113;
    tick();
    tick();
    bus.IFU_rresp = 2'b00;
    check_eq("t8_hold_pc", o_pc, 32'h8000_0304);
    check_eq("t8_hold_valid", 32'(o_valid), 32'd1);
`ifdef YSYX_23060136_IFU_EXC_EN
    check_eq("t8_exc", 32'(o_exc), 32'd1);
    check_eq("t8_cause", 32'(o_exc_cause), 32'd1);
    check_eq("t8_inst", o_inst, NOP);
`else
    check_eq("t8_inst", o_inst, 32'h0020_0113);
`endif

    // misaligned redirect target
    flush  = 1'b1;
    target = 32'h8000_0102;
    tick();
    flush = 1'b0;
`ifdef YSYX_23060136_IFU_EXC_EN
    check_eq("t6_mis_arvalid", 32'(bus.IFU_arvalid), 32'd0);
    check_eq("t6_mis_o_valid", 32'(o_valid), 32'd0);
    tick();
    check_eq("t6_mis_valid", 32'(o_valid), 32'd1);
    check_eq("t6_mis_exc", 32'(o_exc), 32'd1);
    check_eq("t6_mis_cause", 32'(o_exc_cause), 32'd2);
    check_eq("t6_mis_pc", o_pc, 32'h8000_0102);
    check_eq("t6_mis_inst", o_inst, NOP);
`else
    check_eq("t6_align_araddr", bus.IFU_araddr, 32'h8000_0100);
    check_eq("t6_align_arvalid", 32'(bus.IFU_arvalid), 32'd1);
    tick();
    tick();
    check_eq("t6_align_pc", o_pc, 32'h8000_0100);
    check_eq("t6_align_inst", o_inst, 32'h0020_0113);
`endif

    // PC wrap at top of address space
    flush  = 1'b1;
    target = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    check_eq("t9_top_araddr", bus.IFU_araddr, 32'hFFFF_FFFC);
    tick();
    tick();
    check_eq("t9_top_pc", o_pc, 32'hFFFF_FFFC);
`ifdef YSYX_23060136_IFU_EXC_EN
    check_eq("t9_exc_clear", 32'(o_exc), 32'd0);
`endif
    tick();
    check_eq("t9_wrap_araddr", bus.IFU_araddr, 32'h0000_0000);
    check_eq("t9_wrap_arvalid", 32'(bus.IFU_arvalid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
